seq_monitor: RTL

//  Sits directly downstream of the 3-bit even/odd sequence counter and checks its q stream.

---
 rtl/seq_monitor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_monitor.sv
// seq_monitor: lock/flywheel checker for the 3-bit even/odd sequence counter
// stream 2,4,6,0,1,3,5,7 (repeating). Counts mismatches while locked and
// completed periods (matched 7->2 transitions while locked).
module seq_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 2,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned PER_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       d,
  input  logic             in_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [PER_W-1:0] period_cnt,
  output logic [2:0]       expected
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int unsigned MR_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(MISS_MAX + 1);
  localparam logic [MR_W-1:0] LOCK_VAL = MR_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] MISS_VAL = MS_W'(MISS_MAX);

  // Successor of a code in the counter's cycle; total over all 8 codes.
  function automatic logic [2:0] succ(input logic [2:0] x);
    logic [2:0] s;
    case (x)
      3'd2:    s = 3'd4;
      3'd4:    s = 3'd6;
      3'd6:    s = 3'd0;
      3'd0:    s = 3'd1;
      3'd1:    s = 3'd3;
      3'd3:    s = 3'd5;
      3'd5:    s = 3'd7;
      default: s = 3'd2;
    endcase
    return s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [MR_W-1:0]  match_q, match_d, match_inc;
  logic [MS_W-1:0]  miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0] err_q, err_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             pulse_q, pulse_d;
  logic             locked_q;
  logic [2:0]       expected_q;
  logic             hit;

  assign hit       = (d == succ(prev_q));
  assign match_inc = match_q + MR_W'(1);
  assign miss_inc  = miss_q + MS_W'(1);

  // Next-state: seed in IDLE, count matches in HUNT, flywheel/count errors in LOCKED.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    per_d   = per_q;
    pulse_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          prev_d  = d;
          match_d = '0;
          state_d = ST_HUNT;
        end
        ST_HUNT: begin
          prev_d = d;
          if (hit) begin
            if (match_inc == LOCK_VAL) begin
              state_d = ST_LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            prev_d = d;
            miss_d = '0;
            if (prev_q == 3'd7) per_d = per_q + PER_W'(1);
          end else begin
            pulse_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (miss_inc == MISS_VAL) begin
              prev_d  = d;
              match_d = '0;
              miss_d  = '0;
              state_d = ST_HUNT;
            end else begin
              miss_d = miss_inc;
              prev_d = succ(prev_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (err_clr) err_d = '0;
  end

  // State and registered outputs; outputs derive from the next state so the
  // effect of a sample is visible right after the edge that accepts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      per_q      <= '0;
      pulse_q    <= 1'b0;
      locked_q   <= 1'b0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      per_q      <= per_d;
      pulse_q    <= pulse_d;
      locked_q   <= (state_d == ST_LOCKED);
      expected_q <= (state_d == ST_IDLE) ? 3'd0 : succ(prev_d);
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_cnt    = err_q;
  assign period_cnt = per_q;
  assign expected   = expected_q;

endmodule
